// File: rtl/ps2_scan_ctrl_pkg.sv
// Shared types and constants for the PS/2 scan-code sequencing controller.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GOT_E0   = 2'd1,
        GOT_F0   = 2'd2,
        GOT_E0F0 = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    localparam int unsigned EV_W = 10;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ps2_event_t;

    // Odd parity: the nine received bits must contain an odd number of ones.
    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    function automatic ps2_state_e prefix_state(input logic ext, input logic brk);
        ps2_state_e st;
        case ({ext, brk})
            2'b10:   st = GOT_E0;
            2'b01:   st = GOT_F0;
            2'b11:   st = GOT_E0F0;
            default: st = IDLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/ps2_scan_ctrl_if.sv
// Receiver-side inputs, event handshake and error pulses of the scan-code controller.
interface ps2_scan_if;

    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       rx_parity;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic       err_parity;
    logic       err_overflow;
    logic       err_timeout;

    modport slave (
        input  rx_done_tick, rx_data, rx_parity, ev_ready,
        output ev_valid, ev_code, ev_ext, ev_break,
        output err_parity, err_overflow, err_timeout
    );

    modport master (
        output rx_done_tick, rx_data, rx_parity, ev_ready,
        input  ev_valid, ev_code, ev_ext, ev_break,
        input  err_parity, err_overflow, err_timeout
    );

endinterface

// File: rtl/ps2_scan_ctrl_event_fifo.sv
// First-word fall-through event FIFO; a push into a full FIFO without a pop is dropped and flagged.
module ps2_event_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 10
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         drop_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          drop_q;
    logic          pop_ok, push_ok, drop_d;

    always_comb begin
        empty_o = (count_q == '0);
        full_o  = (count_q == CW'(DEPTH));
        pop_ok  = pop_i && !empty_o;
        // A pop in the same cycle frees the slot the push needs.
        push_ok = push_i && (!full_o || pop_ok);
        drop_d  = push_i && full_o && !pop_ok;
        data_o  = mem_q[rd_ptr_q];
        drop_o  = drop_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
        end else begin
            drop_q <= drop_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ps2_scan_ctrl.sv
// PS/2 scan-code sequencer: parity check, E0/F0 prefix tracking, timeout and event FIFO.
// Optional typematic repeat filter enabled by defining PS2_TYPEMATIC_FILTER_EN.
module ps2_scan_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic        reloj,
    input  logic        reset,
    ps2_scan_if.slave   bus
);

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ps2_state_e       state_q;
    logic [CNT_W-1:0] tmo_cnt_q;
    logic             err_parity_q;
    logic             err_timeout_q;

    logic       byte_good, byte_bad;
    logic       is_ext, is_brk;
    logic       cur_ext, cur_brk;
    logic       emit, push, pop;
    ps2_event_t ev_new, ev_head;
    logic       fifo_empty, fifo_full, fifo_drop;

    always_comb begin
        byte_good = bus.rx_done_tick &&  parity_ok(bus.rx_data, bus.rx_parity);
        byte_bad  = bus.rx_done_tick && !parity_ok(bus.rx_data, bus.rx_parity);
        is_ext    = (bus.rx_data == PS2_PREFIX_EXT);
        is_brk    = (bus.rx_data == PS2_PREFIX_BRK);
        cur_ext   = (state_q == GOT_E0) || (state_q == GOT_E0F0);
        cur_brk   = (state_q == GOT_F0) || (state_q == GOT_E0F0);
        emit      = byte_good && !is_ext && !is_brk;
        ev_new    = '{code: bus.rx_data, ext: cur_ext, brk: cur_brk};
        pop       = bus.ev_ready && !fifo_empty;
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       held_valid_q;
    logic       held_ext_q;
    logic [7:0] held_code_q;
    logic       held_match, accepted;

    always_comb begin
        held_match = held_valid_q && (held_ext_q == ev_new.ext) && (held_code_q == ev_new.code);
        push       = emit && !(held_match && !ev_new.brk);
        // Only events that actually enter the FIFO update the held key.
        accepted   = push && (!fifo_full || pop);
    end

    always_ff @(posedge reloj) begin
        if (!reset) begin
            held_valid_q <= 1'b0;
            held_ext_q   <= 1'b0;
            held_code_q  <= '0;
        end else if (accepted) begin
            if (!ev_new.brk) begin
                held_valid_q <= 1'b1;
                held_ext_q   <= ev_new.ext;
                held_code_q  <= ev_new.code;
            end else if (held_match) begin
                held_valid_q <= 1'b0;
            end
        end
    end
`else
    logic unused_full;
    assign push        = emit;
    assign unused_full = fifo_full;
`endif

    always_ff @(posedge reloj) begin
        if (!reset) begin
            state_q       <= IDLE;
            tmo_cnt_q     <= '0;
            err_parity_q  <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            err_parity_q  <= byte_bad;
            err_timeout_q <= 1'b0;
            if (bus.rx_done_tick) begin
                // A byte arriving on the timeout cycle takes priority over the timeout.
                tmo_cnt_q <= '0;
                if (byte_bad || emit) begin
                    state_q <= IDLE;
                end else begin
                    state_q <= prefix_state(cur_ext | is_ext, cur_brk | is_brk);
                end
            end else if (state_q == IDLE) begin
                tmo_cnt_q <= '0;
            end else if (tmo_cnt_q == CNT_LAST) begin
                state_q       <= IDLE;
                err_timeout_q <= 1'b1;
                tmo_cnt_q     <= '0;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
            end
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EV_W)
    ) u_fifo (
        .clk_i   (reloj),
        .rst_ni  (reset),
        .push_i  (push),
        .data_i  (ev_new),
        .pop_i   (pop),
        .data_o  (ev_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .drop_o  (fifo_drop)
    );

    assign bus.ev_valid     = !fifo_empty;
    assign bus.ev_code      = ev_head.code;
    assign bus.ev_ext       = ev_head.ext;
    assign bus.ev_break     = ev_head.brk;
    assign bus.err_parity   = err_parity_q;
    assign bus.err_overflow = fifo_drop;
    assign bus.err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Self-checking bench for ps2_scan_ctrl: queue-based event model plus directed literal checks.
module tb_ps2_scan_ctrl;
    import ps2_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 50;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ps2_scan_if bus ();

    ps2_scan_ctrl #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .reloj (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_make_seen = 0;
    int n_brk_seen  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pending prefix flags, cycles spent pending, queue of expected events.
    logic [9:0] mq[$];
    bit         pend_ext = 0, pend_brk = 0;
    int         idle = 0;
    bit         exp_perr = 0, exp_ovf = 0, exp_to = 0;
    bit         held_v = 0, held_ext = 0;
    logic [7:0] held_code = '0;
    logic [9:0] m_ev;
    bit         m_keep;

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            pend_ext = 0; pend_brk = 0; idle = 0;
            exp_perr = 0; exp_ovf = 0; exp_to = 0;
            held_v = 0;
        end else begin
            exp_perr = 0; exp_ovf = 0; exp_to = 0;
            if (mq.size() > 0 && bus.ev_ready) mq.delete(0);
            if (bus.rx_done_tick) begin
                idle = 0;
                if ((^bus.rx_data) == bus.rx_parity) begin
                    exp_perr = 1; pend_ext = 0; pend_brk = 0;
                end else if (bus.rx_data == 8'hE0) begin
                    pend_ext = 1;
                end else if (bus.rx_data == 8'hF0) begin
                    pend_brk = 1;
                end else begin
                    m_ev = {bus.rx_data, pend_ext, pend_brk};
                    pend_ext = 0; pend_brk = 0;
                    m_keep = 1;
`ifdef PS2_TYPEMATIC_FILTER_EN
                    if (!m_ev[0] && held_v && held_ext == m_ev[1] && held_code == m_ev[9:2]) m_keep = 0;
`endif
                    if (m_keep) begin
                        if (mq.size() < DEPTH) begin
                            mq.push_back(m_ev);
`ifdef PS2_TYPEMATIC_FILTER_EN
                            if (!m_ev[0]) begin
                                held_v = 1; held_ext = m_ev[1]; held_code = m_ev[9:2];
                            end else if (held_v && held_ext == m_ev[1] && held_code == m_ev[9:2]) begin
                                held_v = 0;
                            end
`endif
                        end else begin
                            exp_ovf = 1;
                        end
                    end
                end
            end else if (pend_ext || pend_brk) begin
                idle++;
                if (idle == TMO) begin
                    exp_to = 1; pend_ext = 0; pend_brk = 0; idle = 0;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("ev_valid", bus.ev_valid, mq.size() != 0);
        if (mq.size() != 0) chk("ev_head", {bus.ev_code, bus.ev_ext, bus.ev_break}, mq[0]);
        chk("err_parity", bus.err_parity, exp_perr);
        chk("err_overflow", bus.err_overflow, exp_ovf);
        chk("err_timeout", bus.err_timeout, exp_to);
        if (bus.ev_valid && bus.ev_ready) begin
            if (bus.ev_break) n_brk_seen++;
            else n_make_seen++;
        end
    end

    task automatic send(input logic [7:0] b, input bit good);
        @(posedge clk);
        #1;
        bus.rx_data      = b;
        bus.rx_parity    = good ? ~^b : ^b;
        bus.rx_done_tick = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_done_tick = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    logic [7:0] ovf_codes [5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    int base_m, base_b;

    initial begin
        bus.rx_done_tick = 1'b0;
        bus.rx_data      = '0;
        bus.rx_parity    = 1'b0;
        bus.ev_ready     = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_valid", bus.ev_valid, 0);
        chk("reset_code", {bus.ev_code, bus.ev_ext, bus.ev_break}, 0);
        chk("reset_errs", {bus.err_parity, bus.err_overflow, bus.err_timeout}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single plain code, valid exactly one cycle
        bus.ev_ready = 1'b1;
        send(8'h1C, 1);
        @(negedge clk);
        chk("t1_valid", bus.ev_valid, 1);
        chk("t1_head", {bus.ev_code, bus.ev_ext, bus.ev_break}, {8'h1C, 2'b00});
        @(negedge clk);
        chk("t1_valid_off", bus.ev_valid, 0);

        // Extended break
        do_reset();
        send(8'hE0, 1); send(8'hF0, 1); send(8'h74, 1);
        @(negedge clk);
        chk("t2_head", {bus.ev_valid, bus.ev_code, bus.ev_ext, bus.ev_break}, {1'b1, 8'h74, 2'b11});

        // Bad-parity prefix discarded
        do_reset();
        send(8'hF0, 0);
        @(negedge clk);
        chk("t3_perr", bus.err_parity, 1);
        send(8'h1C, 1);
        @(negedge clk);
        chk("t3_head", {bus.ev_valid, bus.ev_code, bus.ev_ext, bus.ev_break}, {1'b1, 8'h1C, 2'b00});

        // Timeout of a pending F0
        do_reset();
        send(8'hF0, 1);
        repeat (50) @(negedge clk);
        chk("t4_to_early", bus.err_timeout, 0);
        @(negedge clk);
        chk("t4_to_pulse", bus.err_timeout, 1);
        @(negedge clk);
        chk("t4_to_clear", bus.err_timeout, 0);
        send(8'h1C, 1);
        @(negedge clk);
        chk("t4_head", {bus.ev_valid, bus.ev_code, bus.ev_ext, bus.ev_break}, {1'b1, 8'h1C, 2'b00});

        // Byte lands on the timeout cycle: the byte wins
        send(8'hF0, 1);
        repeat (48) @(posedge clk);
        send(8'h1C, 1);
        @(negedge clk);
        chk("t4b_head", {bus.ev_valid, bus.ev_code, bus.ev_ext, bus.ev_break}, {1'b1, 8'h1C, 2'b01});
        chk("t4b_no_to", bus.err_timeout, 0);

        // Overflow with consumer stalled, then drain in order
        do_reset();
        bus.ev_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(ovf_codes[i], 1);
        @(negedge clk);
        chk("t5_ovf", bus.err_overflow, 1);
        bus.ev_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t5_order", {bus.ev_valid, bus.ev_code}, {1'b1, ovf_codes[i]});
            @(negedge clk);
        end
        chk("t5_drained", bus.ev_valid, 0);

        // Reset with queued events and a pending prefix
        bus.ev_ready = 1'b0;
        send(8'h33, 1); send(8'h34, 1); send(8'hE0, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_rst_valid", bus.ev_valid, 0);
        chk("t6_rst_code", {bus.ev_code, bus.ev_ext, bus.ev_break}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.ev_ready = 1'b1;
        send(8'h1C, 1);
        @(negedge clk);
        chk("t6_head", {bus.ev_valid, bus.ev_code, bus.ev_ext, bus.ev_break}, {1'b1, 8'h1C, 2'b00});

        // Typematic repeat sequence
        do_reset();
        @(negedge clk);
        base_m = n_make_seen;
        base_b = n_brk_seen;
        send(8'h1C, 1); send(8'h1C, 1); send(8'h1C, 1);
        send(8'hF0, 1); send(8'h1C, 1); send(8'h1C, 1);
        repeat (3) @(negedge clk);
`ifdef PS2_TYPEMATIC_FILTER_EN
        chk("t7_makes", n_make_seen - base_m, 2);
`else
        chk("t7_makes", n_make_seen - base_m, 4);
`endif
        chk("t7_breaks", n_brk_seen - base_b, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
